pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-address generator for the 5-stage pipeline.
//  Holds the architectural fetch PC and presents it to instruction memory over a valid/ready request.
//  Selects the next PC from trap, branch/jump redirect, return-address prediction or PC+4, and supports halt.
//  Sits between hazard/EX redirect logic and the IF stage.
// PARAMETERS
//  XLEN        32            address width (bits)
//  RESET_ADDR  32'h00000000  PC value loaded by reset (XLEN bits)
//  RAS_DEPTH   4             return-address-stack entries (>=2, power of 2); used only with PC_RAS_EN
// PORTS
//  clock            in   1     system clock, rising edge
//  reset_n          in   1     asynchronous active-low reset
//  stall            in   1     hazard-unit hold; blocks sequential advance only
//  halt_req         in   1     enter HALT after current request completes
//  trap_req         in   1     trap redirect, highest priority
//  trap_target      in   XLEN  trap vector address
//  redirect_valid   in   1     EX-stage branch/jump resolution redirect
//  redirect_target  in   XLEN  redirect address
//  pred_ret         in   1     instruction at fetch_pc predecodes as a return
//  ras_push         in   1     decode saw a call; push ras_push_addr
//  ras_push_addr    in   XLEN  return address to push
//  fetch_valid      out  1     fetch request valid
//  fetch_ready      in   1     instruction memory accepts request
//  fetch_pc         out  XLEN  requested address
//  fetch_pc_plus4   out  XLEN  fetch_pc + 4
//  misalign_err     out  1     one-cycle pulse: the accepted trap/redirect target had bits[1:0] != 0
//  halted           out  1     FSM in HALT
// BEHAVIOUR
//  - FSM: BOOT -> RUN unconditionally on the first clock after reset release.
//  - RUN -> HALT when halt_req=1 and no request is outstanding (fetch_valid=0 or advance=1).
//  - HALT -> RUN on trap_req or redirect_valid.
//  - Reset (async, reset_n=0): pc=RESET_ADDR, state=BOOT, fetch_valid=0, misalign_err=0, halted=0, RAS count=0.
//  - fetch_valid=1 only in RUN. In BOOT/HALT it is 0 and fetch_pc holds its value.
//  - advance = fetch_valid & fetch_ready & ~stall.
//  - Without advance or redirect, fetch_pc is stable (held request).
//  - Next-PC priority, registered, 1-cycle latency:
//      trap_req > redirect_valid > (advance & pred_ret & RAS non-empty -> RAS top) > advance -> pc+4 > hold.
//  - trap_req and redirect_valid act in any state and regardless of stall/fetch_ready.
//  - A redirect squashes the held request; the new PC is presented with fetch_valid=1 on the next cycle (no bubble).
//  - Redirect targets: bits[1:0] forced to 0 when loaded into the PC; misalign_err pulses in the following cycle.
//  - pc+4 wraps modulo 2^XLEN (e.g. 32'hFFFFFFFC -> 32'h00000000). fetch_pc_plus4 wraps identically.
//  - Reset asserted mid-request: request is dropped immediately (async); no completion is implied.
// CONFIGURATION
//  - PC_RAS_EN defined: circular stack of RAS_DEPTH entries, XLEN bits each.
//      push on ras_push; pop when the RAS-top path is selected.
//      push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
//      pop when empty never occurs (falls back to pc+4).
//      simultaneous push and pop: top entry replaced, count unchanged.
//      trap_req clears count to 0.
//  - PC_RAS_EN undefined: no stack storage.
//      pred_ret, ras_push and ras_push_addr are ignored; sequential path is always pc+4.
// TESTING
//  - Reset and boot: reset_n=0 -> fetch_valid=0, fetch_pc=RESET_ADDR.
//      Release -> BOOT for 1 cycle, then fetch_valid=1, fetch_pc=0x0; fetch_ready=1 -> 0x4, 0x8.
//  - Backpressure and stall: fetch_ready=0 for 3 cycles, or stall=1 -> fetch_pc held at 0x8.
//      redirect_valid=1, target 0x200 during stall -> next cycle fetch_pc=0x200, fetch_valid=1.
//  - Priority and misalignment: same cycle trap_req (0x100) + redirect (0x300) -> fetch_pc=0x100.
//      redirect to 0x303 -> fetch_pc=0x300 and misalign_err=1 for exactly one cycle.
//  - Wrap and halt: PC=32'hFFFFFFFC advance -> 0x0, fetch_pc_plus4=0x4.
//      halt_req with accepted request -> halted=1, fetch_valid=0; redirect to 0x40 -> RUN at 0x40.
//  - RAS (PC_RAS_EN, depth 4): push 0x10,0x20,0x30,0x40,0x50, then pred_ret x5 -> targets 0x50,0x40,0x30,0x20, then pc+4.
//      Same-cycle push 0x99 + pop -> top=0x99. trap_req -> stack empty.
//  - Async reset mid-request: assert reset_n=0 off clock edge with fetch_valid=1 -> outputs reach reset values before next edge.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, issues valid/ready requests and picks the next PC.
// Optional return-address stack is compiled in when PC_RAS_EN is defined.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = {XLEN{1'b0}},
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            clock_i,
    input  logic            reset_n_i,
    input  logic            stall_i,
    input  logic            halt_req_i,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            pred_ret_i,
    input  logic            ras_push_i,
    input  logic [XLEN-1:0] ras_push_addr_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic [XLEN-1:0] fetch_pc_plus4_o,
    output logic            misalign_err_o,
    output logic            halted_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q;
    logic            fetch_valid_q, fetch_valid_d;
    logic            halted_q, halted_d;
    logic            misalign_q, misalign_d;

    logic            advance_s;
    logic            jump_s;
    logic            ras_hit_s;
    logic            ras_pop_s;
    logic [XLEN-1:0] ras_top_s;

    assign advance_s = fetch_valid_q & fetch_ready_i & ~stall_i;
    assign jump_s    = trap_req_i | redirect_valid_i;

    // State register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a trap or redirect always lands in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!jump_s && halt_req_i && (!fetch_valid_q || advance_s)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (jump_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered
    always_comb begin
        fetch_valid_d = 1'b0;
        halted_d      = 1'b0;
        case (state_d)
            ST_RUN:  fetch_valid_d = 1'b1;
            ST_HALT: halted_d      = 1'b1;
            default: begin
                fetch_valid_d = 1'b0;
                halted_d      = 1'b0;
            end
        endcase
    end

    // Next-PC selection: trap > redirect > RAS top > pc+4 > hold
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        ras_pop_s  = 1'b0;
        if (trap_req_i) begin
            pc_d       = {trap_target_i[XLEN-1:2], 2'b00};
            misalign_d = |trap_target_i[1:0];
        end else if (redirect_valid_i) begin
            pc_d       = {redirect_target_i[XLEN-1:2], 2'b00};
            misalign_d = |redirect_target_i[1:0];
        end else if (advance_s && ras_hit_s) begin
            pc_d      = ras_top_s;
            ras_pop_s = 1'b1;
        end else if (advance_s) begin
            pc_d = pc_q + XLEN'(32'd4);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and registered outputs
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_q          <= RESET_ADDR;
            pc_plus4_q    <= RESET_ADDR + XLEN'(32'd4);
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_d + XLEN'(32'd4);
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ras_top_q, ras_top_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic             ras_wr_s;
    logic [PTR_W-1:0] ras_wr_idx_s;

    assign ras_hit_s = pred_ret_i & (ras_cnt_q != CNT_W'(0));
    assign ras_top_s = ras_q[ras_top_q];

    // Stack pointer/count update; a full push wraps onto the oldest slot
    always_comb begin
        ras_top_d    = ras_top_q;
        ras_cnt_d    = ras_cnt_q;
        ras_wr_s     = 1'b0;
        ras_wr_idx_s = ras_top_q;
        if (trap_req_i) begin
            ras_cnt_d = CNT_W'(0);
        end else if (ras_push_i && ras_pop_s) begin
            ras_wr_s = 1'b1;
        end else if (ras_push_i) begin
            ras_top_d    = ras_top_q + PTR_W'(1);
            ras_wr_idx_s = ras_top_q + PTR_W'(1);
            ras_wr_s     = 1'b1;
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end else begin
                ras_cnt_d = ras_cnt_q;
            end
        end else if (ras_pop_s) begin
            ras_top_d = ras_top_q - PTR_W'(1);
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end else begin
            ras_top_d = ras_top_q;
        end
    end

    // Stack storage and pointers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ras_top_q <= PTR_W'(0);
            ras_cnt_q <= CNT_W'(0);
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            ras_top_q <= ras_top_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_wr_s) begin
                ras_q[ras_wr_idx_s] <= ras_push_addr_i;
            end
        end
    end
`else
    logic unused_ras_s;

    assign ras_hit_s    = 1'b0;
    assign ras_top_s    = {XLEN{1'b0}};
    assign unused_ras_s = ^{pred_ret_i, ras_push_i, ras_push_addr_i, ras_pop_s};
`endif

    assign fetch_valid_o    = fetch_valid_q;
    assign fetch_pc_o       = pc_q;
    assign fetch_pc_plus4_o = pc_plus4_q;
    assign misalign_err_o   = misalign_q;
    assign halted_o         = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, RAS sequence, randomized run against a model.
module tb_pc_gen;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_A = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, halt_req = 1'b0, trap_req = 1'b0, redir = 1'b0;
    logic [31:0] trap_tgt = 32'h0, redir_tgt = 32'h0, push_addr = 32'h0;
    logic        pred_ret = 1'b0, ras_push = 1'b0, ready = 1'b0;
    logic        f_valid, mis_err, halted;
    logic [31:0] f_pc, f_pc4;

    int checks = 0;
    int failures = 0;

    pc_gen #(.XLEN(32), .RESET_ADDR(RST_A), .RAS_DEPTH(DEPTH)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .stall_i(stall), .halt_req_i(halt_req),
        .trap_req_i(trap_req), .trap_target_i(trap_tgt),
        .redirect_valid_i(redir), .redirect_target_i(redir_tgt),
        .pred_ret_i(pred_ret), .ras_push_i(ras_push), .ras_push_addr_i(push_addr),
        .fetch_valid_o(f_valid), .fetch_ready_i(ready), .fetch_pc_o(f_pc),
        .fetch_pc_plus4_o(f_pc4), .misalign_err_o(mis_err), .halted_o(halted)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=boot 1=run 2=halt, RAS kept as a queue (back = top)
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RST_A;
        m_mis  = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        bit   run     = (m_mode == 1);
        bit   adv     = run && ready && !stall;
        bit   jump    = trap_req || redir;
        bit   use_ras = 1'b0;
        bit   popped  = 1'b0;
        int   nmode   = m_mode;
`ifdef PC_RAS_EN
        use_ras = adv && pred_ret && (m_ras.size() > 0);
`endif
        m_mis = 1'b0;
        if (trap_req) begin
            m_pc  = trap_tgt & 32'hFFFF_FFFC;
            m_mis = (trap_tgt % 4) != 0;
            m_ras.delete();
        end else if (redir) begin
            m_pc  = redir_tgt & 32'hFFFF_FFFC;
            m_mis = (redir_tgt % 4) != 0;
        end else if (use_ras) begin
            m_pc   = m_ras.pop_back();
            popped = 1'b1;
        end else if (adv) begin
            m_pc = m_pc + 32'd4;
        end
`ifdef PC_RAS_EN
        if (ras_push && !trap_req) begin
            if (!popped && m_ras.size() == DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(push_addr);
        end
`endif
        if (m_mode == 0) nmode = 1;
        else if (m_mode == 1 && !jump && halt_req && adv) nmode = 2;
        else if (m_mode == 2 && jump) nmode = 1;
        m_mode = nmode;
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".valid"},  {31'd0, f_valid}, {31'd0, m_mode == 1});
        chk({tag, ".pc"},     f_pc, m_pc);
        chk({tag, ".pc4"},    f_pc4, m_pc + 32'd4);
        chk({tag, ".mis"},    {31'd0, mis_err}, {31'd0, m_mis});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode == 2});
    endtask

    // One clock: drive inputs, advance model, check after the edge
    task automatic cyc(input logic rdy, input logic stl, input logic hlt,
                       input logic trp, input logic [31:0] ttg,
                       input logic rdr, input logic [31:0] rtg,
                       input logic pr, input logic psh, input logic [31:0] pa,
                       input string tag);
        ready = rdy; stall = stl; halt_req = hlt;
        trap_req = trp; trap_tgt = ttg; redir = rdr; redir_tgt = rtg;
        pred_ret = pr; ras_push = psh; push_addr = pa;
        model_step();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    // Reset asserted off the clock edge; outputs must clear before the next edge
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        ready = 1'b0; stall = 1'b0; halt_req = 1'b0; trap_req = 1'b0; redir = 1'b0;
        pred_ret = 1'b0; ras_push = 1'b0;
        #1;
        chk({tag, ".rst_valid"},  {31'd0, f_valid}, 32'd0);
        chk({tag, ".rst_pc"},     f_pc, RST_A);
        chk({tag, ".rst_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, ".rst_mis"},    {31'd0, mis_err}, 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy, stl, hlt, trp;
        logic [31:0] ttg;
        logic        rdr;
        logic [31:0] rtg;
        logic        ev;
        logic [31:0] epc;
        logic        eh, em;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rdy, input logic stl, input logic hlt, input logic trp,
                       input logic [31:0] ttg, input logic rdr, input logic [31:0] rtg,
                       input logic ev, input logic [31:0] epc, input logic eh, input logic em);
        vec_t v;
        v.rdy = rdy; v.stl = stl; v.hlt = hlt; v.trp = trp; v.ttg = ttg;
        v.rdr = rdr; v.rtg = rtg; v.ev = ev; v.epc = epc; v.eh = eh; v.em = em;
        vq.push_back(v);
    endtask

    initial begin
        model_reset();
        //    rdy   stl   hlt   trp   ttg           rdr   rtg           valid pc            halt  mis
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h200,      1'b1, 32'h0000_0200, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h100,      1'b1, 32'h300,      1'b1, 32'h0000_0100, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h303,      1'b1, 32'h0000_0300, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0300, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       1'b1, 32'h0000_0040, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0044, 1'b0, 1'b0);

        do_reset("boot");
        for (int i = 0; i < vq.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cyc(vq[i].rdy, vq[i].stl, vq[i].hlt, vq[i].trp, vq[i].ttg, vq[i].rdr, vq[i].rtg,
                1'b0, 1'b0, 32'h0, t);
            chk({t, ".exp_valid"},  {31'd0, f_valid}, {31'd0, vq[i].ev});
            chk({t, ".exp_pc"},     f_pc, vq[i].epc);
            chk({t, ".exp_pc4"},    f_pc4, vq[i].epc + 32'd4);
            chk({t, ".exp_halted"}, {31'd0, halted}, {31'd0, vq[i].eh});
            chk({t, ".exp_mis"},    {31'd0, mis_err}, {31'd0, vq[i].em});
        end

`ifdef PC_RAS_EN
        begin
            logic [31:0] exp_ret[5];
            exp_ret = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h24};
            do_reset("ras");
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, "ras_go");
            for (int i = 1; i <= 5; i++)
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10 * i, "ras_push");
            for (int i = 0; i < 5; i++) begin
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "ras_pop");
                chk($sformatf("ras_ret%0d", i), f_pc, exp_ret[i]);
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAA, "ras_pushAA");
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h99, "ras_swap");
            chk("ras_swap_pc", f_pc, 32'hAA);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "ras_top99");
            chk("ras_top99_pc", f_pc, 32'h99);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77, "ras_push77");
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "ras_trap");
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "ras_cleared");
            chk("ras_cleared_pc", f_pc, 32'h504);
        end
`endif

        do_reset("rand");
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tt, rt;
            tt = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 31) == 0, tt, $urandom_range(0, 11) == 0, rt,
                $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom, "rand");
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, "pre_async");
        chk("async_pre_valid", {31'd0, f_valid}, 32'd1);
        do_reset("async");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "post_async");
        chk("async_reboot_pc", f_pc, RST_A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
